// File: rtl/llc_spu_counter.sv
// Per-core LLC traffic counters fed by snooped AXI AR/AW/R handshakes.
// Exposes read/write/outstanding counts through a small register port.
module llc_spu_counter #(
  parameter int unsigned NumCores    = 4,
  parameter int unsigned IdWidth     = 8,
  parameter int unsigned CntWidth    = 32,
  parameter int unsigned CoreIdxBase = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ar_valid_i,
  input  logic               ar_ready_i,
  input  logic [IdWidth-1:0] ar_id_i,
  input  logic               aw_valid_i,
  input  logic               aw_ready_i,
  input  logic [IdWidth-1:0] aw_id_i,
  input  logic               r_valid_i,
  input  logic               r_ready_i,
  input  logic               r_last_i,
  input  logic [IdWidth-1:0] r_id_i,
  input  logic               cfg_req_i,
  input  logic               cfg_we_i,
  input  logic [7:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               cfg_rvalid_o,
  output logic               ovf_o
);

  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  cnt_t rd_q [NumCores];
  cnt_t rd_d [NumCores];
  cnt_t wr_q [NumCores];
  cnt_t wr_d [NumCores];
  cnt_t os_q [NumCores];
  cnt_t os_d [NumCores];

  logic [NumCores-1:0] rd_ovf_q, rd_ovf_d;
  logic [NumCores-1:0] wr_ovf_q, wr_ovf_d;
  logic [NumCores-1:0] undf_q, undf_d;
  logic                en_q, en_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q;

  logic ar_hs, aw_hs, rl_hs;
  logic ctrl_wr, clr;
  logic [31:0] status;

  assign ar_hs = ar_valid_i & ar_ready_i;
  assign aw_hs = aw_valid_i & aw_ready_i;
  assign rl_hs = r_valid_i & r_ready_i & r_last_i;

  assign ctrl_wr = cfg_req_i & cfg_we_i & (cfg_addr_i == 8'h00);
  assign clr     = ctrl_wr & cfg_wdata_i[1];

  logic unused;
  assign unused = ^{cfg_wdata_i[31:2], ar_id_i[IdWidth-4:0],
                    aw_id_i[IdWidth-4:0], r_id_i[IdWidth-4:0]};

  // Crossbar master index lives in the top three ID bits
  function automatic logic is_core(input logic [IdWidth-1:0] id,
                                   input int unsigned c);
    return 32'(id[IdWidth-1 -: 3]) == CoreIdxBase + c;
  endfunction

  always_comb begin
    logic ar_c, aw_c, rl_c;
    en_d     = ctrl_wr ? cfg_wdata_i[0] : en_q;
    rd_ovf_d = rd_ovf_q;
    wr_ovf_d = wr_ovf_q;
    undf_d   = undf_q;
    for (int unsigned c = 0; c < NumCores; c++) begin
      rd_d[c] = rd_q[c];
      wr_d[c] = wr_q[c];
      os_d[c] = os_q[c];
      ar_c = ar_hs & is_core(ar_id_i, c);
      aw_c = aw_hs & is_core(aw_id_i, c);
      rl_c = rl_hs & is_core(r_id_i, c);
      if (en_q && ar_c) begin
        if (rd_q[c] == CntMax) rd_ovf_d[c] = 1'b1;
        else                   rd_d[c] = rd_q[c] + 1'b1;
      end
      if (en_q && aw_c) begin
        if (wr_q[c] == CntMax) wr_ovf_d[c] = 1'b1;
        else                   wr_d[c] = wr_q[c] + 1'b1;
      end
      if (ar_c && !rl_c) begin
        if (os_q[c] != CntMax) os_d[c] = os_q[c] + 1'b1;
      end else if (rl_c && !ar_c) begin
        if (os_q[c] == '0) undf_d[c] = 1'b1;
        else               os_d[c] = os_q[c] - 1'b1;
      end
      if (clr) begin
        rd_d[c] = '0;
        wr_d[c] = '0;
      end
    end
    if (clr) begin
      rd_ovf_d = '0;
      wr_ovf_d = '0;
      undf_d   = '0;
    end
  end

  always_comb begin
    status = '0;
    status[NumCores-1:0]       = undf_q;
    status[8 +: NumCores]      = wr_ovf_q;
    status[8+NumCores +: NumCores] = rd_ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    if (cfg_req_i && !cfg_we_i) begin
      if (cfg_addr_i == 8'h00) rdata_d = {31'd0, en_q};
      if (cfg_addr_i == 8'h04) rdata_d = status;
      for (int unsigned c = 0; c < NumCores; c++) begin
        if (cfg_addr_i == 8'(32'h10 + 8*c)) rdata_d = 32'(rd_q[c]);
        if (cfg_addr_i == 8'(32'h14 + 8*c)) rdata_d = 32'(wr_q[c]);
        if (cfg_addr_i == 8'(32'h40 + 4*c)) rdata_d = 32'(os_q[c]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumCores; c++) begin
        rd_q[c] <= '0;
        wr_q[c] <= '0;
        os_q[c] <= '0;
      end
      rd_ovf_q <= '0;
      wr_ovf_q <= '0;
      undf_q   <= '0;
      en_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NumCores; c++) begin
        rd_q[c] <= rd_d[c];
        wr_q[c] <= wr_d[c];
        os_q[c] <= os_d[c];
      end
      rd_ovf_q <= rd_ovf_d;
      wr_ovf_q <= wr_ovf_d;
      undf_q   <= undf_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
      rvalid_q <= cfg_req_i;
    end
  end

  assign cfg_rdata_o  = rdata_q;
  assign cfg_rvalid_o = rvalid_q;
  assign ovf_o        = |{rd_ovf_q, wr_ovf_q};

endmodule

// File: tb/tb_llc_spu_counter.sv
// Bench for llc_spu_counter: directed register tables, corner sequences
// and randomized traffic against a per-core event model.
module tb_llc_spu_counter;

  localparam int MAXC = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_valid, ar_ready, aw_valid, aw_ready;
  logic        r_valid, r_ready, r_last;
  logic [7:0]  ar_id, aw_id, r_id;
  logic        cfg_req, cfg_we;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        cfg_rvalid, ovf;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  llc_spu_counter #(
    .NumCores(4), .IdWidth(8), .CntWidth(4), .CoreIdxBase(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_id_i(ar_id),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_id_i(aw_id),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .r_id_i(r_id),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
    .cfg_rvalid_o(cfg_rvalid), .ovf_o(ovf)
  );

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic idle();
    ar_valid = 0; ar_ready = 0; ar_id = 0;
    aw_valid = 0; aw_ready = 0; aw_id = 0;
    r_valid = 0; r_ready = 0; r_last = 0; r_id = 0;
    cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_req = 1; cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_req = 0; cfg_we = 0;
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    cfg_req = 1; cfg_we = 0; cfg_addr = a;
    tick();
    cfg_req = 0;
    check("rvalid", 32'(cfg_rvalid), 32'd1);
    d = cfg_rdata;
  endtask

  task automatic run_tbl();
    logic [31:0] d;
    foreach (tbl[i]) begin
      cfg_read(tbl[i].addr, d);
      check(tbl[i].name, d, tbl[i].exp);
    end
    tbl.delete();
  endtask

  task automatic ar_one(input logic [7:0] id);
    ar_valid = 1; ar_ready = 1; ar_id = id;
    tick();
    ar_valid = 0; ar_ready = 0;
  endtask

  task automatic rlast_one(input logic [7:0] id);
    r_valid = 1; r_ready = 1; r_last = 1; r_id = id;
    tick();
    r_valid = 0; r_ready = 0; r_last = 0;
  endtask

  // Behavioural model: plain per-core event counts
  int m_rd[4], m_wr[4], m_os[4];
  bit m_rdo[4], m_wro[4], m_ud[4];
  bit m_en;

  function automatic int core_of(input logic [7:0] id);
    int idx = int'(id) / 32;
    return (idx >= 4 && idx < 8) ? idx - 4 : -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int ai = int'(a);
    logic [31:0] s = 0;
    if (ai == 0) return {31'd0, m_en};
    if (ai == 4) begin
      for (int c = 0; c < 4; c++)
        s = s | (32'(m_ud[c]) << c) | (32'(m_wro[c]) << (8 + c))
              | (32'(m_rdo[c]) << (12 + c));
      return s;
    end
    if (ai >= 16 && ai < 48)
      return (ai % 8 == 0) ? 32'(m_rd[(ai-16)/8]) : 32'(m_wr[(ai-16)/8]);
    if (ai >= 64 && ai < 80) return 32'(m_os[(ai-64)/4]);
    return 0;
  endfunction

  function automatic void model_step();
    bit clr = cfg_req && cfg_we && cfg_addr == 0 && cfg_wdata[1];
    for (int c = 0; c < 4; c++) begin
      bit arc = ar_valid && ar_ready && core_of(ar_id) == c;
      bit awc = aw_valid && aw_ready && core_of(aw_id) == c;
      bit rlc = r_valid && r_ready && r_last && core_of(r_id) == c;
      int delta = int'(arc) - int'(rlc);
      if (m_en && arc) begin
        if (m_rd[c] == MAXC) m_rdo[c] = 1; else m_rd[c]++;
      end
      if (m_en && awc) begin
        if (m_wr[c] == MAXC) m_wro[c] = 1; else m_wr[c]++;
      end
      if (delta > 0 && m_os[c] < MAXC) m_os[c]++;
      else if (delta < 0) begin
        if (m_os[c] == 0) m_ud[c] = 1; else m_os[c]--;
      end
      if (clr) begin
        m_rd[c] = 0; m_wr[c] = 0;
        m_rdo[c] = 0; m_wro[c] = 0; m_ud[c] = 0;
      end
    end
    if (cfg_req && cfg_we && cfg_addr == 0) m_en = cfg_wdata[0];
  endfunction

  logic [31:0] rd_val, exp_rd;
  bit          rd_pend;

  initial begin
    idle();
    rst_n = 0;
    #3;
    check("rst_ovf", 32'(ovf), 0);
    check("rst_rvalid", 32'(cfg_rvalid), 0);
    check("rst_rdata", cfg_rdata, 0);
    tick();
    rst_n = 1;
    tick();

    tbl.push_back('{"rst_ctrl", 8'h00, 32'h0});
    tbl.push_back('{"rst_status", 8'h04, 32'h0});
    tbl.push_back('{"rst_rd0", 8'h10, 32'h0});
    tbl.push_back('{"rst_wr0", 8'h14, 32'h0});
    tbl.push_back('{"rst_os0", 8'h40, 32'h0});
    tbl.push_back('{"unmapped08", 8'h08, 32'h0});
    run_tbl();

    // Three core-1 reads
    cfg_write(8'h00, 32'h1);
    repeat (3) ar_one(8'hA3);
    tbl.push_back('{"ctrl_en", 8'h00, 32'h1});
    tbl.push_back('{"rd1", 8'h18, 32'h3});
    tbl.push_back('{"os1", 8'h44, 32'h3});
    tbl.push_back('{"rd0", 8'h10, 32'h0});
    tbl.push_back('{"wr1", 8'h1C, 32'h0});
    tbl.push_back('{"rd2", 8'h20, 32'h0});
    tbl.push_back('{"os0", 8'h40, 32'h0});
    tbl.push_back('{"os2", 8'h48, 32'h0});
    tbl.push_back('{"status0", 8'h04, 32'h0});
    run_tbl();

    // Core-2 outstanding: coincident AR/R-last, then underflow
    ar_one(8'hC0);
    ar_valid = 1; ar_ready = 1; ar_id = 8'hC0;
    r_valid = 1; r_ready = 1; r_last = 1; r_id = 8'hC0;
    tick();
    idle();
    cfg_read(8'h48, rd_val); check("os2_same", rd_val, 1);
    rlast_one(8'hC0);
    cfg_read(8'h48, rd_val); check("os2_dec", rd_val, 0);
    rlast_one(8'hC0);
    cfg_read(8'h48, rd_val); check("os2_undf", rd_val, 0);
    cfg_read(8'h04, rd_val); check("status_undf2", rd_val, 32'h4);
    // R without last must not decrement
    r_valid = 1; r_ready = 1; r_last = 0; r_id = 8'hA3;
    tick();
    idle();

    // Serial-link ID is ignored
    ar_one(8'h20);
    tbl.push_back('{"sl_rd0", 8'h10, 32'h0});
    tbl.push_back('{"sl_rd1", 8'h18, 32'h3});
    tbl.push_back('{"sl_rd2", 8'h20, 32'h2});
    tbl.push_back('{"sl_rd3", 8'h28, 32'h0});
    tbl.push_back('{"sl_os0", 8'h40, 32'h0});
    tbl.push_back('{"sl_os1", 8'h44, 32'h3});
    run_tbl();

    // Write-counter saturation
    aw_valid = 1; aw_ready = 1; aw_id = 8'h80;
    repeat (16) tick();
    idle();
    cfg_read(8'h14, rd_val); check("wr0_sat", rd_val, 32'hF);
    cfg_read(8'h04, rd_val); check("status_ovf", rd_val, 32'h104);
    check("ovf_o_set", 32'(ovf), 1);
    cfg_write(8'h14, 32'h0);
    cfg_write(8'h3C, 32'h5);
    cfg_read(8'h14, rd_val); check("ro_wr0", rd_val, 32'hF);
    // Counting stops with en cleared but OUTST still tracks
    cfg_write(8'h00, 32'h0);
    ar_one(8'h80);
    cfg_read(8'h10, rd_val); check("dis_rd0", rd_val, 0);
    cfg_read(8'h40, rd_val); check("dis_os0", rd_val, 1);
    rlast_one(8'h80);

    // Clear + enable in the same cycle as a core-3 read
    ar_valid = 1; ar_ready = 1; ar_id = 8'hE0;
    cfg_write(8'h00, 32'h3);
    idle();
    tbl.push_back('{"clr_rd3", 8'h28, 32'h0});
    tbl.push_back('{"clr_ctrl", 8'h00, 32'h1});
    tbl.push_back('{"clr_os3", 8'h4C, 32'h1});
    tbl.push_back('{"clr_os1", 8'h44, 32'h3});
    tbl.push_back('{"clr_wr0", 8'h14, 32'h0});
    tbl.push_back('{"clr_status", 8'h04, 32'h0});
    run_tbl();
    check("clr_ovf_o", 32'(ovf), 0);

    // Asynchronous reset with live counters
    aw_valid = 1; aw_ready = 1; aw_id = 8'h80;
    repeat (16) tick();
    idle();
    check("pre_rst_ovf", 32'(ovf), 1);
    rst_n = 0;
    #1;
    check("arst_ovf", 32'(ovf), 0);
    tick();
    rst_n = 1;
    tick();
    tbl.push_back('{"arst_ctrl", 8'h00, 32'h0});
    tbl.push_back('{"arst_status", 8'h04, 32'h0});
    tbl.push_back('{"arst_wr0", 8'h14, 32'h0});
    tbl.push_back('{"arst_os1", 8'h44, 32'h0});
    tbl.push_back('{"arst_os3", 8'h4C, 32'h0});
    run_tbl();

    // Randomized traffic against the model
    for (int c = 0; c < 4; c++) begin
      m_rd[c] = 0; m_wr[c] = 0; m_os[c] = 0;
      m_rdo[c] = 0; m_wro[c] = 0; m_ud[c] = 0;
    end
    m_en = 0;
    for (int i = 0; i < 2000; i++) begin
      ar_valid = 1'($urandom_range(0, 1));
      ar_ready = 1'($urandom_range(0, 1));
      ar_id    = 8'($urandom_range(0, 255));
      aw_valid = 1'($urandom_range(0, 1));
      aw_ready = 1'($urandom_range(0, 1));
      aw_id    = 8'($urandom_range(0, 255));
      r_valid  = 1'($urandom_range(0, 1));
      r_ready  = ($urandom_range(0, 3) != 0);
      r_last   = ($urandom_range(0, 3) != 0);
      r_id     = 8'($urandom_range(0, 255));
      cfg_req  = ($urandom_range(0, 2) == 0);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 8'($urandom_range(0, 23) * 4);
      cfg_wdata = $urandom;
      if (cfg_addr == 0 && $urandom_range(0, 15) != 0) cfg_wdata[1] = 0;
      exp_rd  = model_read(cfg_addr);
      rd_pend = cfg_req && !cfg_we;
      tick();
      check("rnd_rvalid", 32'(cfg_rvalid), 32'(cfg_req));
      if (rd_pend) check("rnd_rdata", cfg_rdata, exp_rd);
      model_step();
      check("rnd_ovf", 32'(ovf),
            32'((m_rdo[0] | m_rdo[1] | m_rdo[2] | m_rdo[3]) |
                (m_wro[0] | m_wro[1] | m_wro[2] | m_wro[3])));
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/llc_spu_counter.md
LLC_SPU_COUNTER -- requirements
Module: llc_spu_counter

Interface
REQ-001 Parameter NumCores, default 4, number of monitored CVA6 cores.
REQ-002 Parameter IdWidth, default 8, snooped AXI ID width (5 base bits + 3 crossbar master-index MSBs).
REQ-003 Parameter CntWidth, default 32, width of each event counter.
REQ-004 Parameter CoreIdxBase, default 4, crossbar master index of Core_0; Core_n = CoreIdxBase+n.
REQ-005 Clocking: single clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 ar_valid_i, ar_ready_i  in  1 each  snooped AR handshake at LLC input.
REQ-009 ar_id_i  in  IdWidth  snooped AR ID.
REQ-010 aw_valid_i, aw_ready_i  in  1 each  snooped AW handshake.
REQ-011 aw_id_i  in  IdWidth  snooped AW ID.
REQ-012 r_valid_i, r_ready_i, r_last_i  in  1 each  snooped R handshake and last beat.
REQ-013 r_id_i  in  IdWidth  snooped R ID.
REQ-014 cfg_req_i  in  1  register access strobe, one cycle per access.
REQ-015 cfg_we_i  in  1  1 = write, 0 = read.
REQ-016 cfg_addr_i  in  8  word-aligned byte address.
REQ-017 cfg_wdata_i  in  32  write data.
REQ-018 cfg_rdata_o  out  32  read data.
REQ-019 cfg_rvalid_o  out  1  access completion, one cycle after cfg_req_i.
REQ-020 ovf_o  out  1  sticky OR of all counter saturation flags.

Function
REQ-021 Handshake = valid & ready in the same cycle; the block never drives the AXI signals.
REQ-022 Master index = ID[IdWidth-1:IdWidth-3]; core c = index - CoreIdxBase; an event counts only if CoreIdxBase <= index < CoreIdxBase+NumCores.
REQ-023 Per core c: RD_CNT[c] +1 per AR handshake, WR_CNT[c] +1 per AW handshake, OUTST[c] +1 per AR handshake and -1 per R handshake with r_last_i=1.
REQ-024 Same-cycle AR handshake and R-last for the same core leaves OUTST[c] unchanged.
REQ-025 RD_CNT/WR_CNT saturate at all-ones and set the matching OVF bit; they never wrap.
REQ-026 R-last with OUTST[c]=0 keeps OUTST[c] at 0 and sets sticky UNDF[c].
REQ-027 Counting only while CTRL.en=1; OUTST tracks regardless of en.
REQ-028 Register map: 0x00 CTRL (bit0 en RW, bit1 clr W1 self-clearing, reads 0); 0x04 STATUS (bits[NumCores-1:0] UNDF, bits[2*NumCores-1+8:8] OVF); 0x10+8c RD_CNT[c]; 0x14+8c WR_CNT[c]; 0x40+4c OUTST[c]; unmapped reads return 0, unmapped writes ignored.
REQ-029 clr=1 zeroes RD_CNT, WR_CNT, OVF, UNDF next cycle; it wins over a same-cycle event; OUTST is not cleared.
REQ-030 Counter registers are read-only; writes to them are ignored.
REQ-031 Read data is sampled from the pre-update value of the access cycle; cfg_rvalid_o pulses exactly one cycle after every cfg_req_i.
REQ-032 ovf_o is combinational OR of the OVF bits.
REQ-033 CTRL write of en and clr together: clear applies and en takes the written value.

Reset
REQ-034 On rst_ni=0: all counters, OUTST, OVF, UNDF, CTRL.en = 0; cfg_rvalid_o = 0, cfg_rdata_o = 0, ovf_o = 0; effect immediate, asynchronous.
REQ-035 Reset asserted mid-transaction discards in-flight OUTST state; no stale outstanding count survives.

Verification
REQ-036 en=1; 3 AR handshakes with ID=8'hA3 (index 5 -> core 1) -> RD_CNT[1]=3, OUTST[1]=3, other counters 0.
REQ-037 OUTST[2]=1; AR (ID 8'hC0) and R-last (ID 8'hC0) in the same cycle -> OUTST[2]=1; next R-last -> 0; a further R-last -> OUTST[2]=0, STATUS bit2=1.
REQ-038 CntWidth=4; 16 AW handshakes from core 0 (ID 8'h80) -> WR_CNT[0]=4'hF, STATUS bit8=1, ovf_o=1.
REQ-039 AR from ID 8'h20 (index 1, Serial_Link) -> no counter changes.
REQ-040 Write CTRL=0x3 in the same cycle as a core-3 AR -> RD_CNT[3]=0, en=1; OUTST[3]=1.
REQ-041 rst_ni low for one cycle with nonzero counters -> all registers read 0 and ovf_o=0 immediately.
